// File: rtl/mmm_result_collector_if.sv
// mmm_result_collector_if: word-in / result-out bus of the MMM result collector.
// Rev 1.0
`default_nettype none

interface mmm_result_collector_if #(
  parameter int W = 16
);
  logic         IN_VALID;
  logic [W-1:0] SR_INs;
  logic [W-1:0] SR_INc;
  logic [W-1:0] N_IN;
  logic [W-1:0] RES_OUT;
  logic         RES_VALID;
  logic         RES_READY;
  logic         RES_LAST;
  logic         RES_CARRY;
  logic         BUSY;
  logic         OVERRUN;

  modport master (
    output IN_VALID, SR_INs, SR_INc, N_IN, RES_READY,
    input  RES_OUT, RES_VALID, RES_LAST, RES_CARRY, BUSY, OVERRUN
  );

  modport slave (
    input  IN_VALID, SR_INs, SR_INc, N_IN, RES_READY,
    output RES_OUT, RES_VALID, RES_LAST, RES_CARRY, BUSY, OVERRUN
  );
endinterface

`default_nettype wire

// File: rtl/mmm_result_collector.sv
// mmm_result_collector: resolves carry-save result words into a K-bit sum and streams it out;
// optional final modular subtraction with MMM_FINAL_SUB_EN.  Rev 1.0
`default_nettype none

module mmm_result_collector #(
  parameter int K = 1024,
  parameter int W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  mmm_result_collector_if.slave bus
);

  localparam int NW = K / W;
  localparam int JW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [JW-1:0] LAST_IDX = JW'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic          cy_q, cy_d;
  logic          res_carry_q, res_carry_d;
  logic          overrun_q, overrun_d;
  logic [W-1:0]  sum_buf_q [NW];

  logic          w_first;
  logic          w_accept;
  logic          w_last;
  logic          w_valid;
  logic          w_cy_in;
  logic          w_cy_out;
  logic          w_res_carry;
  logic [JW-1:0] w_idx;
  logic [W:0]    w_sum_full;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_word;

  // IDLE always means the next accepted word is word 0 of a new result.
  assign w_first    = (state_q == S_IDLE);
  assign w_accept   = bus.IN_VALID && (state_q != S_DRAIN);
  assign w_idx      = w_first ? '0 : j_q;
  assign w_last     = (w_idx == LAST_IDX);
  assign w_cy_in    = w_first ? 1'b0 : cy_q;
  assign w_sum_full = {1'b0, bus.SR_INs} + {1'b0, bus.SR_INc} + {{W{1'b0}}, w_cy_in};
  assign w_sum      = w_sum_full[W-1:0];
  assign w_cy_out   = w_sum_full[W];
  assign w_valid    = (state_q == S_DRAIN);

`ifdef MMM_FINAL_SUB_EN
  logic          bw_q;
  logic          sel_q;
  logic [W-1:0]  d_buf_q [NW];
  logic          w_bw_in;
  logic          w_sel_now;
  logic [W:0]    w_diff_full;

  assign w_bw_in     = w_first ? 1'b0 : bw_q;
  assign w_diff_full = {1'b0, w_sum} - {1'b0, bus.N_IN} - {{W{1'b0}}, w_bw_in};
  // Subtracted value is kept when the sum overflowed K bits or is not below N.
  assign w_sel_now   = w_cy_out | ~w_diff_full[W];
  assign w_res_carry = w_sel_now ? 1'b0 : w_cy_out;
  assign w_word      = sel_q ? d_buf_q[j_q] : sum_buf_q[j_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bw_q  <= 1'b0;
      sel_q <= 1'b0;
    end else if (w_accept) begin
      bw_q <= w_diff_full[W];
      if (w_last) begin
        sel_q <= w_sel_now;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      d_buf_q[w_idx] <= w_diff_full[W-1:0];
    end
  end
`else
  logic w_unused_n;

  assign w_unused_n  = ^bus.N_IN;
  assign w_res_carry = w_cy_out;
  assign w_word      = sum_buf_q[j_q];
`endif

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      sum_buf_q[w_idx] <= w_sum;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      j_q         <= '0;
      cy_q        <= 1'b0;
      res_carry_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      cy_q        <= cy_d;
      res_carry_q <= res_carry_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    cy_d        = cy_q;
    res_carry_d = res_carry_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          if (w_last) begin
            state_d     = S_DRAIN;
            j_d         = '0;
            cy_d        = 1'b0;
            res_carry_d = w_res_carry;
          end else begin
            state_d = S_ACCUM;
            j_d     = w_idx + JW'(1);
            cy_d    = w_cy_out;
          end
        end
      end
      S_DRAIN: begin
        if (bus.IN_VALID) begin
          overrun_d = 1'b1;
        end
        if (bus.RES_READY) begin
          if (j_q == LAST_IDX) begin
            state_d = S_IDLE;
            j_d     = '0;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        j_d     = '0;
      end
    endcase
  end

  assign bus.RES_VALID = w_valid;
  assign bus.RES_OUT   = w_valid ? w_word : '0;
  assign bus.RES_LAST  = w_valid && (j_q == LAST_IDX);
  assign bus.RES_CARRY = res_carry_q;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.OVERRUN   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_mmm_result_collector.sv
// tb_mmm_result_collector: directed vectors for mmm_result_collector at K=64, W=16.
// Rev 1.0
`default_nettype none

module tb_mmm_result_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [15:0] s_v [4];
  logic [15:0] c_v [4];
  logic [15:0] n_v [4];
  logic [15:0] e_v [4];

  mmm_result_collector_if #(.W(16)) bus ();

  mmm_result_collector #(.K(64), .W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit gap, input logic exp_cy);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) begin
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        bus.SR_INs   = 16'hDEAD;
        bus.SR_INc   = 16'hBEEF;
      end
      @(negedge clk);
      bus.IN_VALID = 1'b1;
      bus.SR_INs   = s_v[i];
      bus.SR_INc   = c_v[i];
      bus.N_IN     = n_v[i];
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    check("latency_valid", bus.RES_VALID, 1);
    check("res_carry", bus.RES_CARRY, exp_cy);
  endtask

  task automatic collect(input int stall_beat);
    for (int b = 0; b < 4; b++) begin
      int guard = 0;
      while (!bus.RES_VALID && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("beat_valid", bus.RES_VALID, 1);
      if (b == stall_beat) begin
        bus.RES_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_hold", bus.RES_OUT, e_v[b]);
        end
        bus.RES_READY = 1'b1;
      end
      check("word", bus.RES_OUT, e_v[b]);
      check("last", bus.RES_LAST, (b == 3));
      @(negedge clk);
    end
    check("end_valid", bus.RES_VALID, 0);
    check("end_busy", bus.BUSY, 0);
  endtask

  initial begin
    bus.IN_VALID  = 1'b0;
    bus.SR_INs    = '0;
    bus.SR_INc    = '0;
    bus.N_IN      = '0;
    bus.RES_READY = 1'b1;
    n_v = '{16'h0, 16'h0, 16'h0, 16'h0};

    repeat (2) @(negedge clk);
    check("rst_valid", bus.RES_VALID, 0);
    check("rst_out", bus.RES_OUT, 0);
    check("rst_last", bus.RES_LAST, 0);
    check("rst_carry", bus.RES_CARRY, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_overrun", bus.OVERRUN, 0);
    rst = 1'b0;

    // carry ripple from word 0 into word 1
    s_v = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    c_v = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    e_v = '{16'h0000, 16'h0001, 16'h0000, 16'h0000};
    send(1'b0, 1'b0);
    collect(-1);

    // carry out of the full K-bit sum
    s_v = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    c_v = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    e_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`ifdef MMM_FINAL_SUB_EN
    send(1'b0, 1'b0);
`else
    send(1'b0, 1'b1);
`endif
    collect(-1);

    // idle gap between input words, consumer stall on beat 2
    s_v = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h8000};
    c_v = '{16'h0002, 16'h0000, 16'h0001, 16'h8000};
    e_v = '{16'h0001, 16'h0000, 16'h0002, 16'h0000};
`ifdef MMM_FINAL_SUB_EN
    send(1'b1, 1'b0);
`else
    send(1'b1, 1'b1);
`endif
    collect(1);

    // final subtraction: sum >= N, then sum < N
    n_v = '{16'h0005, 16'h0000, 16'h0000, 16'h0000};
    s_v = '{16'h0007, 16'h0000, 16'h0000, 16'h0000};
    c_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`ifdef MMM_FINAL_SUB_EN
    e_v = '{16'h0002, 16'h0000, 16'h0000, 16'h0000};
`else
    e_v = '{16'h0007, 16'h0000, 16'h0000, 16'h0000};
`endif
    send(1'b0, 1'b0);
    collect(-1);
    s_v = '{16'h0003, 16'h0000, 16'h0000, 16'h0000};
    e_v = '{16'h0003, 16'h0000, 16'h0000, 16'h0000};
    send(1'b0, 1'b0);
    collect(-1);
    n_v = '{16'h0, 16'h0, 16'h0, 16'h0};

    // input word arriving while draining is dropped
    s_v = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    c_v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    e_v = '{16'h2345, 16'h789A, 16'hCDEF, 16'h2334};
    bus.RES_READY = 1'b0;
`ifdef MMM_FINAL_SUB_EN
    send(1'b0, 1'b0);
`else
    send(1'b0, 1'b1);
`endif
    check("drain_busy", bus.BUSY, 1);
    bus.IN_VALID = 1'b1;
    bus.SR_INs   = 16'hAAAA;
    bus.SR_INc   = 16'h5555;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    check("overrun_set", bus.OVERRUN, 1);
    check("overrun_word0", bus.RES_OUT, e_v[0]);
    bus.RES_READY = 1'b1;
    collect(-1);
    check("overrun_sticky", bus.OVERRUN, 1);

    // reset in the middle of accumulation
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.IN_VALID = 1'b1;
      bus.SR_INs   = 16'h7777;
      bus.SR_INc   = 16'h9999;
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    check("mid_busy", bus.BUSY, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", bus.BUSY, 0);
    check("arst_overrun", bus.OVERRUN, 0);
    check("arst_carry", bus.RES_CARRY, 0);
    check("arst_valid", bus.RES_VALID, 0);
    check("arst_out", bus.RES_OUT, 0);
    @(negedge clk);
    rst = 1'b0;
`ifdef MMM_FINAL_SUB_EN
    send(1'b0, 1'b0);
`else
    send(1'b0, 1'b1);
`endif
    collect(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmm_result_collector.md
MMM_RESULT_COLLECTOR -- requirements
Module: mmm_result_collector

Interface
REQ-001 Parameter K, default 1024: operand full size in bits.
REQ-002 Parameter W, default 16: word size; K/W words per result (NW = K/W).
REQ-003 Clock is CLK; reset is RST, asynchronous and active-high.
REQ-004 Port list:
- CLK  in  1  clock
- RST  in  1  async active-high reset
- IN_VALID  in  1  one word strobe from last PE
- SR_INs  in  W  carry-save sum word
- SR_INc  in  W  carry-save carry word
- N_IN  in  W  modulus word aligned with current SR word
- RES_OUT  out  W  result word
- RES_VALID  out  1  RES_OUT valid
- RES_READY  in  1  consumer accepts word
- RES_LAST  out  1  marks word NW-1
- RES_CARRY  out  1  final carry-out of the K-bit sum
- BUSY  out  1  state != IDLE
- OVERRUN  out  1  sticky, input word dropped

Function
REQ-005 Words SHALL arrive LSW first; exactly NW accepted IN_VALID strobes form one result.
REQ-006 States SHALL be IDLE, ACCUM, DRAIN.
REQ-007 IDLE: IN_VALID SHALL store word 0 and enter ACCUM (or DRAIN if NW==1).
REQ-008 ACCUM: each IN_VALID SHALL compute {cy',sum} = SR_INs + SR_INc + cy (W+1 bits) and store sum at word index j.
REQ-009 Word counter j SHALL increment per accepted word; cy SHALL clear at word 0 of each result.
REQ-010 Cycles with IN_VALID low SHALL leave j, cy and buffers unchanged.
REQ-011 On accepting word NW-1: state -> DRAIN next cycle, RES_CARRY <= final cy', j <= 0.
REQ-012 DRAIN: RES_VALID SHALL be high, with RES_OUT = buffer[j] and RES_LAST = (j==NW-1).
REQ-013 Beat transfers when RES_VALID & RES_READY; j increments, and after the RES_LAST beat the state returns to IDLE with RES_VALID low the next cycle.
REQ-014 RES_OUT/RES_LAST SHALL be held stable while RES_VALID & !RES_READY.
REQ-015 IN_VALID during DRAIN SHALL drop the word and set OVERRUN=1 until reset.
REQ-016 Latency: the first RES_VALID SHALL be asserted 1 cycle after the clock edge accepting word NW-1.
REQ-017 N_IN SHALL be ignored when FINAL_SUB_EN is undefined.

Reset
REQ-018 RST high SHALL asynchronously force IDLE and set j=0, cy=0, RES_VALID=0, RES_LAST=0, RES_OUT=0, RES_CARRY=0, BUSY=0, OVERRUN=0.
REQ-019 RST mid-ACCUM or mid-DRAIN SHALL abandon the partial result; the next IN_VALID after release SHALL be treated as word 0.
REQ-020 Buffer contents need not be reset.

Configuration
REQ-021 Macro MMM_FINAL_SUB_EN defined: in parallel with REQ-008, compute {bw',d} = sum - N_IN - bw and store d in a second buffer D, with bw cleared at word 0.
REQ-022 With MMM_FINAL_SUB_EN, DRAIN SHALL output D when (final cy' | ~final bw'), else the sum buffer; selection SHALL be latched at word NW-1 and RES_CARRY SHALL report 0 when D is selected.
REQ-023 Without MMM_FINAL_SUB_EN: no D buffer, no subtractor, and the raw sum SHALL be output.

Verification (K=64, W=16, NW=4)
REQ-024 s={0xFFFF,0,0,0}, c={0x0001,0,0,0}, RES_READY=1 -> RES_OUT 0x0000,0x0001,0x0000,0x0000; RES_LAST on beat 4; RES_CARRY=0.
REQ-025 s all 0xFFFF, c={1,0,0,0}, no final-sub -> four 0x0000 words, RES_CARRY=1.
REQ-026 MMM_FINAL_SUB_EN, N={5,0,0,0}, s={7,0,0,0}, c=0 -> 0x0002,0,0,0; with s={3,0,0,0} -> 0x0003,0,0,0.
REQ-027 RES_READY low for 3 cycles on beat 2 -> RES_OUT held at word 1, no beat lost, order preserved.
REQ-028 IN_VALID pulse during DRAIN -> OVERRUN=1, output words unchanged; RST asserted after 2 words of ACCUM -> all outputs 0 immediately, and a fresh 4-word result completes correctly.
